// File: rtl/poly_osc_mixer.sv
// rtl/poly_osc_mixer.sv - N-voice time-multiplexed oscillator and mixer
//
// One shared datapath serves every voice: on an accepted sample tick the
// shadow configuration is copied to the active set, then voice v is processed
// in RUN cycle v. Each voice goes through phase accumulate, waveform lookup
// and amplitude scaling. The scaled voices are summed, shifted, saturated and
// presented offset-binary.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_sample_tick      1-cycle strobe requesting one output sample
//   i_cfg_we           config write strobe into the shadow registers
//   i_cfg_voice        target voice (out-of-range writes are ignored)
//   i_cfg_sel          0=FCW 1=wave 2=amp 3=phase offset
//   i_cfg_data         LSB-aligned write data
//   o_data             mixed sample, offset binary (0x8000 = zero)
//   o_valid            1-cycle pulse when o_data updates
//   o_busy             high while a sample is being computed
//   o_overrun          1-cycle pulse after a tick was dropped while busy
module poly_osc_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 24,
    parameter int MIX_SHIFT  = 2,
    localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sample_tick,
    input  logic             i_cfg_we,
    input  logic [VW-1:0]    i_cfg_voice,
    input  logic [1:0]       i_cfg_sel,
    input  logic [ACC_W-1:0] i_cfg_data,
    output logic [15:0]      o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_overrun
);

    localparam int SUM_W = 16 + VW + 1;
    localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
    localparam logic [VW:0] NV_W = NUM_VOICES[VW:0];
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-32768);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t state_q, state_d;
    logic [VW-1:0] cnt_q, cnt_d;
    logic tick_ok;

    logic [ACC_W-1:0] fcw_sh_q  [NUM_VOICES];
    logic [2:0]       wave_sh_q [NUM_VOICES];
    logic [15:0]      amp_sh_q  [NUM_VOICES];
    logic [15:0]      ph_sh_q   [NUM_VOICES];
    logic [ACC_W-1:0] fcw_act_q  [NUM_VOICES];
    logic [2:0]       wave_act_q [NUM_VOICES];
    logic [15:0]      amp_act_q  [NUM_VOICES];
    logic [15:0]      ph_act_q   [NUM_VOICES];
    logic [ACC_W-1:0] acc_q      [NUM_VOICES];

    logic [15:0]              lfsr_q;
    logic signed [15:0]       s1_sample_q;
    logic [15:0]              s1_amp_q;
    logic                     s1_valid_q;
    logic signed [SUM_W-1:0]  sum_q;
    logic [15:0]              data_q, data_d;
    logic                     valid_q, overrun_q;

    logic                     voice_ok;
    logic [ACC_W-1:0]         acc_new;
    logic [15:0]              addr;
    logic [15:0]              wave_s;
    logic signed [32:0]       prod;
    logic signed [SUM_W-1:0]  p_ext;
    logic signed [SUM_W-1:0]  mix;
    logic [15:0]              sat;

    assign voice_ok = {1'b0, i_cfg_voice} < NV_W;

    // FSM next state; only a tick seen in IDLE is accepted
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_sample_tick) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    tick_ok = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_V) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + VW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q[0]) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + VW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage 1: phase accumulate, phase offset and waveform for the current voice
    always_comb begin
        acc_new = acc_q[cnt_q] + fcw_act_q[cnt_q];
        addr    = acc_new[ACC_W-1 -: 16] + ph_act_q[cnt_q];
        wave_s  = '0;
        case (wave_act_q[cnt_q])
            3'd1:    wave_s = addr ^ 16'h8000;
            3'd2:    wave_s = addr[15] ? 16'h8000 : 16'h7FFF;
            3'd3:    wave_s = {(addr[15] ? ~addr[14:0] : addr[14:0]), 1'b0} ^ 16'h8000;
            3'd4:    wave_s = lfsr_q ^ 16'h8000;
            default: wave_s = '0;
        endcase
    end

    // Stage 2: signed amplitude scaling; the arithmetic shift floors toward -inf
    assign prod  = s1_sample_q * $signed({1'b0, s1_amp_q});
    assign p_ext = SUM_W'(prod >>> 16);

    assign mix = sum_q >>> MIX_SHIFT;
    always_comb begin
        if (mix > SAT_HI)      sat = 16'h7FFF;
        else if (mix < SAT_LO) sat = 16'h8000;
        else                   sat = mix[15:0];
        data_d = sat ^ 16'h8000;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                fcw_sh_q[v]  <= '0;
                wave_sh_q[v] <= '0;
                amp_sh_q[v]  <= '0;
                ph_sh_q[v]   <= '0;
            end
        end else if (i_cfg_we && voice_ok) begin
            case (i_cfg_sel)
                2'd0:    fcw_sh_q[i_cfg_voice]  <= i_cfg_data;
                2'd1:    wave_sh_q[i_cfg_voice] <= i_cfg_data[2:0];
                2'd2:    amp_sh_q[i_cfg_voice]  <= i_cfg_data[15:0];
                default: ph_sh_q[i_cfg_voice]   <= i_cfg_data[15:0];
            endcase
        end
    end

    // The copy reads the pre-edge shadow values, so a write in the tick cycle
    // only takes effect from the following tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                fcw_act_q[v]  <= '0;
                wave_act_q[v] <= '0;
                amp_act_q[v]  <= '0;
                ph_act_q[v]   <= '0;
                acc_q[v]      <= '0;
            end
        end else if (tick_ok) begin
            fcw_act_q  <= fcw_sh_q;
            wave_act_q <= wave_sh_q;
            amp_act_q  <= amp_sh_q;
            ph_act_q   <= ph_sh_q;
        end else if (state_q == S_RUN) begin
            acc_q[cnt_q] <= acc_new;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lfsr_q      <= 16'hACE1;
            s1_sample_q <= '0;
            s1_amp_q    <= '0;
            s1_valid_q  <= 1'b0;
            sum_q       <= '0;
            data_q      <= 16'h8000;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= (state_q == S_RUN);
            valid_q    <= (state_q == S_DRAIN) && cnt_q[0];
            overrun_q  <= i_sample_tick && (state_q != S_IDLE);
            if (tick_ok) begin
                // Fibonacci taps 16,14,13,11, shifting toward the LSB
                lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            end
            if (state_q == S_RUN) begin
                s1_sample_q <= wave_s;
                s1_amp_q    <= amp_act_q[cnt_q];
            end
            if (tick_ok) begin
                sum_q <= '0;
            end else if (s1_valid_q) begin
                sum_q <= sum_q + p_ext;
            end
            if ((state_q == S_DRAIN) && cnt_q[0]) begin
                data_q <= data_d;
            end
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_poly_osc_mixer.sv
// tb/tb_poly_osc_mixer.sv - directed checks for poly_osc_mixer (MIX_SHIFT 0 and 2)
module tb_poly_osc_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        cfg_we;
    logic [1:0]  cfg_voice;
    logic [1:0]  cfg_sel;
    logic [23:0] cfg_data;
    logic [15:0] data0, data2;
    logic        valid0, valid2, busy0, busy2, ovr0, ovr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    poly_osc_mixer #(.NUM_VOICES(4), .ACC_W(24), .MIX_SHIFT(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_cfg_we(cfg_we),
        .i_cfg_voice(cfg_voice), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
        .o_data(data0), .o_valid(valid0), .o_busy(busy0), .o_overrun(ovr0)
    );

    poly_osc_mixer #(.NUM_VOICES(4), .ACC_W(24), .MIX_SHIFT(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_cfg_we(cfg_we),
        .i_cfg_voice(cfg_voice), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
        .o_data(data2), .o_valid(valid2), .o_busy(busy2), .o_overrun(ovr2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg(input int v, input int sel, input logic [23:0] d);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_voice = 2'(v);
        cfg_sel   = 2'(sel);
        cfg_data  = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic set_voice(input int v, input int wave, input logic [23:0] fcw,
                             input logic [23:0] amp, input logic [23:0] ph);
        cfg(v, 0, fcw);
        cfg(v, 1, 24'(wave));
        cfg(v, 2, amp);
        cfg(v, 3, ph);
    endtask

    // Pulses a tick (optionally with a voice-0 cfg write in the same cycle) and
    // waits a bounded number of cycles for o_valid; lat=0 means it never came.
    task automatic run_tick(input bit wr, input int sel, input logic [23:0] d,
                            output int lat, output logic [15:0] r0,
                            output logic [15:0] r2, output logic busy1);
        @(negedge clk);
        tick = 1'b1;
        if (wr) begin
            cfg_we    = 1'b1;
            cfg_voice = 2'd0;
            cfg_sel   = 2'(sel);
            cfg_data  = d;
        end
        lat   = 0;
        r0    = '0;
        r2    = '0;
        busy1 = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tick   = 1'b0;
                cfg_we = 1'b0;
                busy1  = busy0;
            end
            if (valid0) begin
                lat = k;
                r0  = data0;
                r2  = data2;
            end
        end
    endtask

    int          lat, nval;
    logic [15:0] r0, r2;
    logic        b1, ov4, ov5;

    initial begin
        rst_n     = 1'b0;
        tick      = 1'b0;
        cfg_we    = 1'b0;
        cfg_voice = '0;
        cfg_sel   = '0;
        cfg_data  = '0;

        // Reset state
        @(negedge clk);
        chk("rst_data", data0, 16'h8000);
        chk("rst_valid", valid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_overrun", ovr0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single saw voice, then a back-to-back tick
        set_voice(0, 1, 24'h010000, 24'h00FFFF, 24'h0);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("saw1_latency", lat, 7);
        chk("saw1_busy", b1, 1);
        chk("saw1_data", r0, 16'h0100);
        chk("saw1_data_shift2", r2, 16'h6040);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("saw2_latency", lat, 7);
        chk("saw2_data", r0, 16'h0200);

        // Overrun: second tick 3 cycles after the accepted one is dropped
        do_reset();
        set_voice(0, 1, 24'h010000, 24'h00FFFF, 24'h0);
        @(negedge clk);
        tick = 1'b1;
        nval = 0; lat = 0; r0 = '0; ov4 = 1'b0; ov5 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) tick = 1'b0;
            if (k == 3) tick = 1'b1;
            if (k == 4) begin
                tick = 1'b0;
                ov4  = ovr0;
            end
            if (k == 5) ov5 = ovr0;
            if (valid0) begin
                nval++;
                lat = k;
                r0  = data0;
            end
        end
        chk("ovr_pulse", ov4, 1);
        chk("ovr_one_cycle", ov5, 0);
        chk("ovr_valid_count", nval, 1);
        chk("ovr_latency", lat, 7);
        chk("ovr_data", r0, 16'h0100);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("ovr_next_data", r0, 16'h0200);

        // Cfg write in the tick cycle applies only from the next tick
        do_reset();
        set_voice(0, 1, 24'h010000, 24'h00FFFF, 24'h0);
        run_tick(1, 2, 24'h0, lat, r0, r2, b1);
        chk("amp_same_cycle", r0, 16'h0100);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("amp_next_tick", r0, 16'h8000);

        // Four square voices: saturation vs shift
        do_reset();
        for (int v = 0; v < 4; v++) set_voice(v, 2, 24'h000001, 24'h00FFFF, 24'h0);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("sq4_shift0_sat", r0, 16'hFFFF);
        chk("sq4_shift2", r2, 16'hFFFE);

        // Accumulator wrap and phase offset
        do_reset();
        set_voice(0, 2, 24'hFFFFFF, 24'h00FFFF, 24'h0);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("wrap1_data", r0, 16'h0000);
        chk("wrap1_shift2", r2, 16'h6000);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("wrap2_data", r0, 16'h0000);
        cfg(0, 3, 24'h008000);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("wrap_phase_data", r0, 16'hFFFE);

        // Noise from the LFSR sequence 0xACE1 -> 0x5670 -> 0xAB38
        do_reset();
        set_voice(0, 4, 24'h0, 24'h00FFFF, 24'h0);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("noise1", r0, 16'h5670);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("noise2", r0, 16'hAB37);

        // Triangle, half amplitude, unused wave code
        do_reset();
        set_voice(0, 3, 24'h010000, 24'h00FFFF, 24'h0);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("tri", r0, 16'h0200);
        do_reset();
        set_voice(0, 1, 24'h010000, 24'h008000, 24'h0);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("saw_half_amp", r0, 16'h4080);
        do_reset();
        set_voice(0, 5, 24'h010000, 24'h00FFFF, 24'h0);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("wave5_off", r0, 16'h8000);

        // Reset mid-run aborts immediately with no o_valid afterwards
        do_reset();
        set_voice(0, 1, 24'h010000, 24'h00FFFF, 24'h0);
        run_tick(0, 0, 0, lat, r0, r2, b1);
        chk("pre_abort_data", r0, 16'h0100);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_data", data0, 16'h8000);
        @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (valid0) nval++;
        end
        chk("abort_no_valid", nval, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
